pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the five-stage LC-3b pipeline. It drives the load and flush strobes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB state registers. Its inputs are instruction-fetch and data-memory handshakes, the load-use hazard detector, and the branch-mispredict signal resolved in MEM. A two-state FSM holds a mispredict redirect until any in-flight wrong-path fetch has completed. Saturating counters record stall and redirect events for performance analysis.

Parameters:
CNT_WIDTH, 16, width of stall_count and redirect_count.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
if_mem_req  in  1  instruction fetch outstanding
if_mem_resp  in  1  instruction fetch completes this cycle
mem_mem_req  in  1  MEM stage performing a data read/write
mem_mem_resp  in  1  data access completes this cycle
load_use_hazard  in  1  ID instruction needs result of load currently in EX
mispredict  in  1  branch in MEM resolved opposite to prediction/target
load_pc  out  1  PC register load (selects corrected target when redirect fires)
load_if_id  out  1  IF/ID load
load_id_ex  out  1  ID/EX load
load_ex_mem  out  1  EX/MEM load
load_mem_wb  out  1  MEM/WB load
flush_if_id  out  1  IF/ID loads a nop
flush_id_ex  out  1  ID/EX loads a nop
flush_ex_mem  out  1  EX/MEM loads a nop
mem_wb_nop  out  1  MEM/WB loads a nop
redirect  out  1  pulse: PC redirect executed this cycle
stall_count  out  CNT_WIDTH  cycles with load_pc=0
redirect_count  out  CNT_WIDTH  redirects executed

Behaviour:
- Definitions: dstall = mem_mem_req & ~mem_mem_resp; istall = if_mem_req & ~if_mem_resp.
- All strobe outputs are combinational from the FSM state and the current inputs. Counters and state are registered.
- Reset, asserted: state=RUN; stall_count=0; redirect_count=0; all load_*, flush_*, mem_wb_nop and redirect = 0.
- Reset mid-operation: an assertion at any time, including in FLUSH_PEND, clears any pending redirect.
- FSM states: RUN, FLUSH_PEND.
- RUN, evaluated in priority order:
  1. dstall: all load_*=0 except load_mem_wb=1 with mem_wb_nop=1, so WB does not repeat an instruction. mispredict is ignored; it stays asserted because EX/MEM is frozen.
  2. mispredict & istall: go to FLUSH_PEND. This cycle has the same outputs as case 1.
  3. mispredict: redirect action. All five load_*=1; flush_if_id=flush_id_ex=flush_ex_mem=1; redirect=1; redirect_count+1.
  4. istall: load_pc=0; load_if_id=1 with flush_if_id=1; ID/EX, EX/MEM and MEM/WB load=1 with no flush.
  5. load_use_hazard: load_pc=0; load_if_id=0; load_id_ex=1 with flush_id_ex=1; EX/MEM and MEM/WB load=1.
  6. Otherwise: all load_*=1; all flushes 0.
- FLUSH_PEND:
  - While ~if_mem_resp or dstall: same outputs as RUN case 1.
  - On if_mem_resp & ~dstall: perform the redirect action (RUN case 3) and go to RUN. The fetched wrong-path word is discarded through the IF/ID flush.
  - load_use_hazard and mispredict are ignored in this state.
- stall_count increments each non-reset cycle with load_pc=0. redirect_count increments on each redirect pulse. Both saturate at 2^CNT_WIDTH-1 with no wrap.
- Latency: the redirect takes effect on the edge ending the cycle in which redirect=1; there is no added cycle in RUN.
- Simultaneous if_mem_resp and mispredict in RUN: istall=0, so the redirect fires immediately.

Test Plan:
- Reset then idle, all req=0: all five loads=1 and all flushes=0 every cycle; counters remain 0.
- mem_mem_req=1 for 3 cycles, mem_mem_resp=1 in the 3rd: cycles 1-2 show loads=0, load_mem_wb=1, mem_wb_nop=1; cycle 3 shows all loads=1; stall_count=2.
- mispredict=1 with no stall: the same cycle shows redirect=1, three flushes=1, all loads=1; redirect_count=1; stall_count unchanged.
- mispredict with if_mem_req=1 and if_mem_resp held low 4 cycles, then high: 4 frozen cycles in FLUSH_PEND, then redirect=1 on the resp cycle; back in RUN next cycle; stall_count=4.
- load_use_hazard for 1 cycle: load_pc=0, load_if_id=0, flush_id_ex=1, load_ex_mem=1. Also check istall with hazard together: the istall response (flush_if_id=1) wins.
- CNT_WIDTH=2 with 5 stall cycles: stall_count saturates at 3. Asserting reset in FLUSH_PEND leaves state=RUN and counters=0, and no redirect occurs after release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage LC-3b pipeline.
// Turns fetch/data-memory handshakes, the load-use hazard and the
// MEM-stage mispredict into load/flush strobes for the PC and the four
// pipeline registers. A two-state FSM parks a mispredict redirect until any
// in-flight wrong-path fetch has returned. Saturating counters track stall
// cycles and executed redirects.
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_mem_req,
  input  logic                 if_mem_resp,
  input  logic                 mem_mem_req,
  input  logic                 mem_mem_resp,
  input  logic                 load_use_hazard,
  input  logic                 mispredict,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 mem_wb_nop,
  output logic                 redirect,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  // FSM encoding
  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

  // Per-cycle pipeline action selected by the priority logic
  localparam logic [2:0] ACT_NONE     = 3'd0; // everything held, used under reset
  localparam logic [2:0] ACT_FREEZE   = 3'd1; // data stall: only MEM/WB moves, as a bubble
  localparam logic [2:0] ACT_REDIRECT = 3'd2; // take corrected PC, squash younger stages
  localparam logic [2:0] ACT_ISTALL   = 3'd3; // fetch not back: hold PC, bubble into IF/ID
  localparam logic [2:0] ACT_HAZARD   = 3'd4; // load-use: hold PC and IF/ID, bubble into ID/EX
  localparam logic [2:0] ACT_NORMAL   = 3'd5; // everything advances

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic [CNT_WIDTH-1:0] stall_count_q;
  logic [CNT_WIDTH-1:0] stall_count_d;
  logic [CNT_WIDTH-1:0] redirect_count_q;
  logic [CNT_WIDTH-1:0] redirect_count_d;
  logic [2:0]           act;
  logic                 dstall;
  logic                 istall;

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                   input logic                 en);
    logic [CNT_WIDTH-1:0] res;
    if (en && (val != CNT_MAX)) begin
      res = val + CNT_ONE;
    end else begin
      res = val;
    end
    return res;
  endfunction

  assign dstall = mem_mem_req & ~mem_mem_resp;
  assign istall = if_mem_req & ~if_mem_resp;

  // Pick this cycle's pipeline action and the next FSM state
  always_comb begin
    state_d = state_q;
    act     = ACT_NONE;
    if (reset) begin
      state_d = ST_RUN;
      act     = ACT_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dstall) begin
            // EX/MEM is frozen, so a mispredict stays visible and is handled later
            act = ACT_FREEZE;
          end else if (mispredict && istall) begin
            // wrong-path fetch still outstanding: wait for it before redirecting
            act     = ACT_FREEZE;
            state_d = ST_FLUSH_PEND;
          end else if (mispredict) begin
            act = ACT_REDIRECT;
          end else if (istall) begin
            act = ACT_ISTALL;
          end else if (load_use_hazard) begin
            act = ACT_HAZARD;
          end else begin
            act = ACT_NORMAL;
          end
        end
        ST_FLUSH_PEND: begin
          if (!if_mem_resp || dstall) begin
            act = ACT_FREEZE;
          end else begin
            // returning wrong-path word is dropped by the IF/ID flush
            act     = ACT_REDIRECT;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          act     = ACT_FREEZE;
        end
      endcase
    end
  end

  // Decode the selected action into load/flush strobes
  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mem_wb_nop   = 1'b0;
    redirect     = 1'b0;
    case (act)
      ACT_FREEZE: begin
        load_mem_wb = 1'b1;
        mem_wb_nop  = 1'b1;
      end
      ACT_REDIRECT: begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        redirect     = 1'b1;
      end
      ACT_ISTALL: begin
        load_if_id  = 1'b1;
        flush_if_id = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      ACT_HAZARD: begin
        load_id_ex  = 1'b1;
        flush_id_ex = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      ACT_NORMAL: begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      ACT_NONE: begin
        load_pc = 1'b0;
      end
      default: begin
        load_pc = 1'b0;
      end
    endcase
  end

  // Next values of the performance counters
  always_comb begin
    stall_count_d    = sat_inc(stall_count_q, ~load_pc);
    redirect_count_d = sat_inc(redirect_count_q, redirect);
  end

  // State and counter registers; reset drops any parked redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      stall_count_q    <= {CNT_WIDTH{1'b0}};
      redirect_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      stall_count_q    <= stall_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_count    = stall_count_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic, all checked against a table-driven reference model.
module tb_pipeline_ctrl;

  logic clk;
  logic reset;
  logic if_mem_req, if_mem_resp, mem_mem_req, mem_mem_resp;
  logic load_use_hazard, mispredict;

  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mem_wb_nop, redirect;
  logic [15:0] stall_count, redirect_count;

  logic s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_mem_wb_nop, s_redirect;
  logic [1:0] s_stall_count, s_redirect_count;

  int n_vec;
  int n_err;

  // reference model state
  bit      m_pending;
  int      m_stall;
  int      m_redir;
  int      m_stall_s;
  int      m_redir_s;

  // output patterns: {pc,if_id,id_ex,ex_mem,mem_wb, fl_if_id,fl_id_ex,fl_ex_mem,wb_nop, redirect}
  localparam logic [9:0] P_ZERO   = 10'b00000_0000_0;
  localparam logic [9:0] P_FROZEN = 10'b00001_0001_0;
  localparam logic [9:0] P_REDIR  = 10'b11111_1110_1;
  localparam logic [9:0] P_ISTALL = 10'b01111_1000_0;
  localparam logic [9:0] P_HAZARD = 10'b00111_0100_0;
  localparam logic [9:0] P_NORMAL = 10'b11111_0000_0;

  logic [9:0] dut_vec, sat_vec;
  assign dut_vec = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    flush_if_id, flush_id_ex, flush_ex_mem, mem_wb_nop, redirect};
  assign sat_vec = {s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb,
                    s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_mem_wb_nop, s_redirect};

  pipeline_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .if_mem_req(if_mem_req), .if_mem_resp(if_mem_resp),
    .mem_mem_req(mem_mem_req), .mem_mem_resp(mem_mem_resp),
    .load_use_hazard(load_use_hazard), .mispredict(mispredict),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .mem_wb_nop(mem_wb_nop), .redirect(redirect),
    .stall_count(stall_count), .redirect_count(redirect_count)
  );

  pipeline_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .if_mem_req(if_mem_req), .if_mem_resp(if_mem_resp),
    .mem_mem_req(mem_mem_req), .mem_mem_resp(mem_mem_resp),
    .load_use_hazard(load_use_hazard), .mispredict(mispredict),
    .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
    .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
    .mem_wb_nop(s_mem_wb_nop), .redirect(s_redirect),
    .stall_count(s_stall_count), .redirect_count(s_redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected strobe pattern from the behavioural rules
  function automatic logic [9:0] model_pattern(input bit pend, input bit ireq, input bit iresp,
                                               input bit mreq, input bit mresp,
                                               input bit luh, input bit mp);
    bit dst, ist;
    dst = mreq && !mresp;
    ist = ireq && !iresp;
    if (pend) return (!iresp || dst) ? P_FROZEN : P_REDIR;
    if (dst) return P_FROZEN;
    if (mp && ist) return P_FROZEN;
    if (mp) return P_REDIR;
    if (ist) return P_ISTALL;
    if (luh) return P_HAZARD;
    return P_NORMAL;
  endfunction

  // One clock cycle: apply inputs, check at negedge, advance model at posedge
  task automatic step(input bit ireq, input bit iresp, input bit mreq, input bit mresp,
                      input bit luh, input bit mp);
    logic [9:0] exp;
    bit dst, ist;
    if_mem_req = ireq; if_mem_resp = iresp;
    mem_mem_req = mreq; mem_mem_resp = mresp;
    load_use_hazard = luh; mispredict = mp;
    @(negedge clk);
    exp = model_pattern(m_pending, ireq, iresp, mreq, mresp, luh, mp);
    n_vec++;
    if (dut_vec !== exp) begin
      n_err++;
      $display("FAIL strobes: got %b expected %b (in ireq=%0b iresp=%0b mreq=%0b mresp=%0b luh=%0b mp=%0b)",
               dut_vec, exp, ireq, iresp, mreq, mresp, luh, mp);
    end
    n_vec++;
    if (sat_vec !== exp) begin
      n_err++;
      $display("FAIL strobes_w2: got %b expected %b", sat_vec, exp);
    end
    n_vec++;
    if (stall_count !== 16'(m_stall) || redirect_count !== 16'(m_redir)) begin
      n_err++;
      $display("FAIL counters: got stall=%0d redir=%0d expected stall=%0d redir=%0d",
               stall_count, redirect_count, m_stall, m_redir);
    end
    n_vec++;
    if (s_stall_count !== 2'(m_stall_s) || s_redirect_count !== 2'(m_redir_s)) begin
      n_err++;
      $display("FAIL counters_w2: got stall=%0d redir=%0d expected stall=%0d redir=%0d",
               s_stall_count, s_redirect_count, m_stall_s, m_redir_s);
    end
    @(posedge clk);
    dst = mreq && !mresp;
    ist = ireq && !iresp;
    if (m_pending) m_pending = (!iresp || dst);
    else m_pending = (!dst && mp && ist);
    if (exp[9] == 1'b0) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall_s < 3) m_stall_s++;
    end
    if (exp[0] == 1'b1) begin
      if (m_redir < 65535) m_redir++;
      if (m_redir_s < 3) m_redir_s++;
    end
    #1;
  endtask

  task automatic do_reset();
    if_mem_req = 1'b0; if_mem_resp = 1'b0; mem_mem_req = 1'b0; mem_mem_resp = 1'b0;
    load_use_hazard = 1'b0; mispredict = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    m_pending = 1'b0; m_stall = 0; m_redir = 0; m_stall_s = 0; m_redir_s = 0;
    n_vec++;
    if (dut_vec !== P_ZERO || stall_count !== 16'd0 || redirect_count !== 16'd0 ||
        s_stall_count !== 2'd0 || s_redirect_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: strobes=%b stall=%0d redir=%0d w2 stall=%0d redir=%0d expected all 0",
               dut_vec, stall_count, redirect_count, s_stall_count, s_redirect_count);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec !== P_ZERO || stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_held: strobes=%b stall=%0d expected 0", dut_vec, stall_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input int exp_stall, input int exp_redir);
    n_vec++;
    if (stall_count !== 16'(exp_stall) || redirect_count !== 16'(exp_redir)) begin
      n_err++;
      $display("FAIL %s: got stall=%0d redir=%0d expected stall=%0d redir=%0d",
               name, stall_count, redirect_count, exp_stall, exp_redir);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check_counts("idle_counts", 0, 0);
  endtask

  task automatic test_dstall();
    do_reset();
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);   // mispredict ignored under data stall
    step(0, 0, 1, 1, 0, 0);
    check_counts("dstall_counts", 2, 0);
  endtask

  task automatic test_mispredict();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_counts("redirect_counts", 0, 1);
    step(1, 1, 0, 0, 0, 1);   // resp in the same cycle: redirect immediately
    check_counts("redirect_resp_same", 0, 2);
  endtask

  task automatic test_flush_pend();
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_counts("flush_pend_counts", 4, 1);
    // data stall holds the parked redirect even once the fetch returns
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    check_counts("flush_pend_dstall", 6, 2);
  endtask

  task automatic test_hazard();
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);   // istall wins over hazard
    step(0, 0, 0, 0, 0, 0);
    check_counts("hazard_counts", 2, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    n_vec++;
    if (s_stall_count !== 2'd3 || stall_count !== 16'd5) begin
      n_err++;
      $display("FAIL saturation: got w2=%0d w16=%0d expected 3 and 5", s_stall_count, stall_count);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
    n_vec++;
    if (s_redirect_count !== 2'd3 || redirect_count !== 16'd5) begin
      n_err++;
      $display("FAIL redir_saturation: got w2=%0d w16=%0d expected 3 and 5",
               s_redirect_count, redirect_count);
    end
  endtask

  task automatic test_reset_in_flush_pend();
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_counts("reset_flush_pend", 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_pending = 1'b0; m_stall = 0; m_redir = 0; m_stall_s = 0; m_redir_s = 0;
    reset = 1'b1;
    if_mem_req = 1'b0; if_mem_resp = 1'b0; mem_mem_req = 1'b0; mem_mem_resp = 1'b0;
    load_use_hazard = 1'b0; mispredict = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_idle();
    test_dstall();
    test_mispredict();
    test_flush_pend();
    test_hazard();
    test_saturation();
    test_reset_in_flush_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
